// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arb_pkg;

   localparam int unsigned N_REQ   = 2;
   localparam int unsigned FLAGS_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   // ALUControl codes understood by the shared ALU; other codes pass through untouched
   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_ORR = 3'd3;
   localparam logic [2:0] ALU_LSL = 3'd4;
   localparam logic [2:0] ALU_LSR = 3'd5;
   localparam logic [2:0] ALU_MUL = 3'd6;

   // Bit positions inside the {N,Z,C,V} flag nibble
   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_arb_grant.sv
// One-hot grant selection between two requesters; ptr_i names the requester that wins a tie.
module alu_arb_grant
   import alu_arb_pkg::*;
(
   input  logic [N_REQ-1:0] valid_i,
   input  logic             ptr_i,
   output logic [N_REQ-1:0] grant_c_o
);

   always_comb begin
      grant_c_o = '0;
      if (valid_i == 2'b11) begin
         grant_c_o = ptr_i ? 2'b10 : 2'b01;
      end else begin
         grant_c_o = valid_i;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one external combinational ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed priority to requester 0.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned CTRL_W = 3
) (
   input  logic               clk,
   input  logic               reset,

   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [WIDTH-1:0]   req0_a,
   input  logic [WIDTH-1:0]   req0_b,
   input  logic [CTRL_W-1:0]  req0_ctrl,

   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [WIDTH-1:0]   req1_a,
   input  logic [WIDTH-1:0]   req1_b,
   input  logic [CTRL_W-1:0]  req1_ctrl,

   output logic               rsp0_valid,
   input  logic               rsp0_ready,
   output logic               rsp1_valid,
   input  logic               rsp1_ready,
   output logic [WIDTH-1:0]   rsp_result,
   output logic [FLAGS_W-1:0] rsp_flags,

   output logic [WIDTH-1:0]   alu_a,
   output logic [WIDTH-1:0]   alu_b,
   output logic [CTRL_W-1:0]  alu_ctrl,
   input  logic [WIDTH-1:0]   alu_result,
   input  logic [FLAGS_W-1:0] alu_flags
);

   state_e             state_q;
   logic [WIDTH-1:0]   alu_a_q;
   logic [WIDTH-1:0]   alu_b_q;
   logic [CTRL_W-1:0]  alu_ctrl_q;
   logic               gnt_idx_q;
   logic [N_REQ-1:0]   rsp_valid_q;
   logic [WIDTH-1:0]   rsp_result_q;
   logic [FLAGS_W-1:0] rsp_flags_q;

   logic [N_REQ-1:0]   req_valid_c;
   logic [N_REQ-1:0]   grant_c;
   logic               ptr_c;
   logic               accept_c;
   logic               rsp_hs_c;
   logic [WIDTH-1:0]   sel_a_c;
   logic [WIDTH-1:0]   sel_b_c;
   logic [CTRL_W-1:0]  sel_ctrl_c;

   assign req_valid_c = {req1_valid, req0_valid};

`ifdef ALU_ARB_ROUND_ROBIN_EN
   logic ptr_q;

   // Tie-break pointer: after every grant, the other requester gets priority
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= 1'b0;
      end else if (accept_c && (|grant_c)) begin
         ptr_q <= ~grant_c[1];
      end
   end

   assign ptr_c = ptr_q;
`else
   assign ptr_c = 1'b0;
`endif

   alu_arb_grant u_grant (
      .valid_i   (req_valid_c),
      .ptr_i     (ptr_c),
      .grant_c_o (grant_c)
   );

   // Handshake is combinational so a request is taken in the same IDLE cycle it is seen
   assign accept_c   = (state_q == IDLE) && !reset;
   assign req0_ready = accept_c & grant_c[0];
   assign req1_ready = accept_c & grant_c[1];

   assign sel_a_c    = grant_c[1] ? req1_a    : req0_a;
   assign sel_b_c    = grant_c[1] ? req1_b    : req0_b;
   assign sel_ctrl_c = grant_c[1] ? req1_ctrl : req0_ctrl;

   // Only the granted requester's consume strobe can release the response
   assign rsp_hs_c = gnt_idx_q ? rsp1_ready : rsp0_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_ctrl_q   <= '0;
         gnt_idx_q    <= 1'b0;
         rsp_valid_q  <= '0;
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|grant_c) begin
                  alu_a_q    <= sel_a_c;
                  alu_b_q    <= sel_b_c;
                  alu_ctrl_q <= sel_ctrl_c;
                  gnt_idx_q  <= grant_c[1];
                  state_q    <= EXEC;
               end
            end
            EXEC: begin
               rsp_result_q <= alu_result;
               rsp_flags_q  <= alu_flags;
               alu_a_q      <= '0;
               alu_b_q      <= '0;
               alu_ctrl_q   <= '0;
               rsp_valid_q  <= gnt_idx_q ? 2'b10 : 2'b01;
               state_q      <= RESP;
            end
            RESP: begin
               if (rsp_hs_c) begin
                  rsp_valid_q <= '0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_ctrl   = alu_ctrl_q;
   assign rsp0_valid = rsp_valid_q[0];
   assign rsp1_valid = rsp_valid_q[1];
   assign rsp_result = rsp_result_q;
   assign rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: supplies the ALU, keeps a transaction-level model, and runs directed vectors.
module tb_alu_arbiter;
   import alu_arb_pkg::*;

`ifdef ALU_ARB_ROUND_ROBIN_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [2:0]  req0_ctrl, req1_ctrl;
   logic        rsp0_valid, rsp1_valid;
   logic        rsp0_ready, rsp1_ready;
   logic [31:0] rsp_result;
   logic [3:0]  rsp_flags;
   logic [31:0] alu_a, alu_b;
   logic [2:0]  alu_ctrl;
   logic [31:0] alu_result;
   logic [3:0]  alu_flags;

   int checks = 0;
   int errors = 0;

   alu_arbiter #(.WIDTH(32), .CTRL_W(3)) dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_ctrl  (req0_ctrl),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_ctrl  (req1_ctrl),
      .rsp0_valid (rsp0_valid),
      .rsp0_ready (rsp0_ready),
      .rsp1_valid (rsp1_valid),
      .rsp1_ready (rsp1_ready),
      .rsp_result (rsp_result),
      .rsp_flags  (rsp_flags),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_ctrl   (alu_ctrl),
      .alu_result (alu_result),
      .alu_flags  (alu_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU: returns {flags, result}; unknown codes give a ^ b
   function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] c);
      logic [32:0] wide;
      logic [31:0] r;
      logic [3:0]  f;
      logic        cf, vf;
      r = '0; cf = 1'b0; vf = 1'b0; wide = '0;
      case (c)
         ALU_ADD: begin
            wide = {1'b0, a} + {1'b0, b};
            r = wide[31:0]; cf = wide[32];
            vf = (a[31] == b[31]) && (r[31] != a[31]);
         end
         ALU_SUB: begin
            wide = {1'b0, a} + {1'b0, ~b} + 33'd1;
            r = wide[31:0]; cf = wide[32];
            vf = (a[31] != b[31]) && (r[31] != a[31]);
         end
         ALU_AND: r = a & b;
         ALU_ORR: r = a | b;
         ALU_LSL: r = a << b[4:0];
         ALU_LSR: r = a >> b[4:0];
         ALU_MUL: r = a * b;
         default: r = a ^ b;
      endcase
      f = '0;
      f[FLAG_N] = r[31];
      f[FLAG_Z] = (r == 32'd0);
      f[FLAG_C] = cf;
      f[FLAG_V] = vf;
      return {f, r};
   endfunction

   always_comb {alu_flags, alu_result} = alu_fn(alu_a, alu_b, alu_ctrl);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Transaction-level model: an op accepted in cycle t drives the ALU in t+1
   // and is offered to its owner from t+2 until consumed.
   bit          m_ok = 1'b0;
   int          m_cyc = 0;
   bit          m_busy = 1'b0;
   int          m_acc = 0;
   bit          m_idx = 1'b0;
   bit          m_prio = 1'b0;
   logic [31:0] m_a = '0, m_b = '0;
   logic [2:0]  m_c = '0;
   logic [31:0] m_res = '0;
   logic [3:0]  m_flg = '0;
   logic [1:0]  e_vld, e_ready, e_rspv;
   bit          e_pick, e_exec;

   always @(negedge clk) begin
      e_vld = {req1_valid, req0_valid};
      if (e_vld == 2'b11) e_pick = RR_EN ? m_prio : 1'b0;
      else                e_pick = e_vld[1];
      e_ready = (!reset && !m_busy && (|e_vld)) ? (e_pick ? 2'b10 : 2'b01) : 2'b00;
      e_exec  = m_busy && (m_cyc == m_acc + 1);
      e_rspv  = (m_busy && (m_cyc >= m_acc + 2)) ? (m_idx ? 2'b10 : 2'b01) : 2'b00;
      if (m_ok) begin
         check("req_ready",  {req1_ready, req0_ready}, e_ready);
         check("rsp_valid",  {rsp1_valid, rsp0_valid}, e_rspv);
         check("alu_a",      alu_a,    e_exec ? m_a : 32'd0);
         check("alu_b",      alu_b,    e_exec ? m_b : 32'd0);
         check("alu_ctrl",   alu_ctrl, e_exec ? m_c : 3'd0);
         check("rsp_result", rsp_result, m_res);
         check("rsp_flags",  rsp_flags,  m_flg);
      end
      if (reset) begin
         m_busy = 1'b0; m_res = '0; m_flg = '0; m_prio = 1'b0; m_ok = 1'b1;
      end else if (!m_busy) begin
         if (|e_vld) begin
            m_busy = 1'b1; m_acc = m_cyc; m_idx = e_pick; m_prio = !e_pick;
            m_a = e_pick ? req1_a : req0_a;
            m_b = e_pick ? req1_b : req0_b;
            m_c = e_pick ? req1_ctrl : req0_ctrl;
         end
      end else begin
         if (e_exec) {m_flg, m_res} = alu_fn(m_a, m_b, m_c);
         if ((e_rspv != 2'b00) && (m_idx ? rsp1_ready : rsp0_ready)) m_busy = 1'b0;
      end
      m_cyc++;
   end

   task automatic set_req(input bit k, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] c);
      if (k) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ctrl = c; end
      else   begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ctrl = c; end
   endtask

   task automatic wait_accept(input bit k, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = k ? req1_ready : req0_ready;
         tick();
      end
      if (!ok) fail_now("accept_timeout");
   endtask

   task automatic run_op(input bit k, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] c, output logic [31:0] res,
                         output logic [3:0] fl, output int lat);
      bit ok;
      res = '0; fl = '0; lat = -1;
      if (k) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
      set_req(k, a, b, c);
      wait_accept(k, ok);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      if (ok) begin
         ok = 1'b0;
         for (int i = 1; i <= 20 && !ok; i++) begin
            @(negedge clk);
            if (k ? rsp1_valid : rsp0_valid) begin
               ok = 1'b1; lat = i; res = rsp_result; fl = rsp_flags;
            end
            tick();
         end
         if (!ok) fail_now("rsp_timeout");
      end
   endtask

   task automatic op_check(input string nm, input bit k, input logic [31:0] a,
                           input logic [31:0] b, input logic [2:0] c,
                           input logic [31:0] exp_res, input logic [3:0] exp_fl);
      logic [31:0] res;
      logic [3:0]  fl;
      int          lat;
      run_op(k, a, b, c, res, fl, lat);
      check({nm, "_latency"}, lat, 2);
      check({nm, "_result"}, res, exp_res);
      check({nm, "_flags"},  fl,  exp_fl);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   int       gnt[4];
   int       gcyc[4];
   int       n;
   int       cyc;
   bit       ok;

   initial begin
      reset = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = '0; req0_b = '0; req0_ctrl = '0;
      req1_a = '0; req1_b = '0; req1_ctrl = '0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      repeat (3) tick();
      reset = 1'b0;

      @(negedge clk);
      check("reset_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
      check("reset_result",    rsp_result, 32'd0);
      check("reset_flags",     rsp_flags,  4'd0);
      check("reset_alu",       {alu_a, alu_b}, 64'd0);
      tick();

      op_check("add0",  1'b0, 32'd5,          32'd3,          ALU_ADD, 32'd8,          4'b0000);
      op_check("sub1",  1'b1, 32'd3,          32'd5,          ALU_SUB, 32'hFFFF_FFFE,  4'b1000);
      op_check("subz",  1'b0, 32'd7,          32'd7,          ALU_SUB, 32'd0,          4'b0110);
      op_check("addc",  1'b1, 32'hFFFF_FFFF,  32'd1,          ALU_ADD, 32'd0,          4'b0110);
      op_check("addv",  1'b0, 32'h7FFF_FFFF,  32'd1,          ALU_ADD, 32'h8000_0000,  4'b1001);
      op_check("and1",  1'b1, 32'hF0F0_F0F0,  32'hFF00_FF00,  ALU_AND, 32'hF000_F000,  4'b1000);
      op_check("orr0",  1'b0, 32'h0F,         32'hF0,         ALU_ORR, 32'hFF,         4'b0000);
      op_check("lsl1",  1'b1, 32'd1,          32'd4,          ALU_LSL, 32'h10,         4'b0000);
      op_check("lsr0",  1'b0, 32'h8000_0000,  32'd31,         ALU_LSR, 32'd1,          4'b0000);
      op_check("mul1",  1'b1, 32'd6,          32'd7,          ALU_MUL, 32'h2A,         4'b0000);
      op_check("unk0",  1'b0, 32'hA5,         32'h0F,         3'd7,    32'hAA,         4'b0000);

      // Contention from a fresh pointer, both consumers always ready
      pulse_reset();
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      set_req(1'b0, 32'd1, 32'd2, ALU_ADD);
      set_req(1'b1, 32'd9, 32'd4, ALU_SUB);
      n = 0; cyc = 0;
      while (n < 4 && cyc < 40) begin
         @(negedge clk);
         if (req0_ready)      begin gnt[n] = 0; gcyc[n] = cyc; n++; end
         else if (req1_ready) begin gnt[n] = 1; gcyc[n] = cyc; n++; end
         tick();
         cyc++;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      if (n < 4) fail_now("contention_grants");
      else begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
         check("cont_g0", gnt[0], 0); check("cont_g1", gnt[1], 1);
         check("cont_g2", gnt[2], 0); check("cont_g3", gnt[3], 1);
`else
         check("cont_g0", gnt[0], 0); check("cont_g1", gnt[1], 0);
         check("cont_g2", gnt[2], 0); check("cont_g3", gnt[3], 0);
`endif
         check("cont_spacing1", gcyc[1] - gcyc[0], 3);
         check("cont_spacing3", gcyc[3] - gcyc[2], 3);
      end
      repeat (4) tick();

      // Backpressure on requester 0 while requester 1 waits; rsp1_ready must be ignored
      rsp0_ready = 1'b0; rsp1_ready = 1'b1;
      set_req(1'b0, 32'd10, 32'd20, ALU_ADD);
      wait_accept(1'b0, ok);
      req0_valid = 1'b0;
      set_req(1'b1, 32'd1, 32'd1, ALU_SUB);
      tick();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_rsp0_valid", rsp0_valid, 1'b1);
         check("bp_result",     rsp_result, 32'd30);
         check("bp_req1_ready", req1_ready, 1'b0);
         tick();
      end
      rsp0_ready = 1'b1;
      @(negedge clk);
      check("bp_release_req1_ready", req1_ready, 1'b0);
      tick();
      @(negedge clk);
      check("bp_next_req1_ready", req1_ready, 1'b1);
      tick();
      req1_valid = 1'b0;
      repeat (4) tick();

      // Request dropped before grant gets no response
      set_req(1'b0, 32'd2, 32'd2, ALU_ADD);
      wait_accept(1'b0, ok);
      req0_valid = 1'b0;
      set_req(1'b1, 32'd3, 32'd3, ALU_ADD);
      tick();
      req1_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("drop_rsp1_valid", rsp1_valid, 1'b0);
         tick();
      end

      // Reset while the operation is in EXEC
      set_req(1'b0, 32'd11, 32'd22, ALU_ADD);
      wait_accept(1'b0, ok);
      req0_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("rst_exec_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
      check("rst_exec_alu",       {alu_a, alu_b}, 64'd0);
      check("rst_exec_ctrl",      alu_ctrl, 3'd0);
      check("rst_exec_result",    rsp_result, 32'd0);
      check("rst_exec_flags",     rsp_flags, 4'd0);
      tick();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_exec_no_rsp", rsp0_valid, 1'b0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1);
   end

endmodule
